// File: rtl/multicycle_control_fsm.sv
// Multicycle processor main control unit.
// Sequences FETCH/DECODE and the per-instruction execute/writeback states
// for lw, sw, R-type, beq, addi and j. Datapath controls are Moore outputs
// of the current state. PCEn also folds in the branch condition. Illegal is
// a registered one-cycle flag raised after an unsupported opcode or an
// unused state encoding is seen.
module multicycle_control_fsm (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [5:0] Op,
    input  logic       Zero,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCEn,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic [3:0] State,
    output logic       Illegal
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q;
    state_t state_d;
    logic   illegal_d;
    logic   pc_write;
    logic   branch;

    // State register and registered Illegal flag; reset aborts any instruction.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_FETCH;
            Illegal <= 1'b0;
        end else begin
            state_q <= state_d;
            Illegal <= illegal_d;
        end
    end

    // Next-state decode; bad opcodes and unused encodings fall back to FETCH.
    always_comb begin
        state_d   = S_FETCH;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = S_FETCH;
            S_EXECUTE: state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BEQEX:   state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JEX:     state_d = S_FETCH;
            default: begin
                state_d   = S_FETCH;
                illegal_d = 1'b1;
            end
        endcase
    end

    // Moore control outputs; everything not set for a state stays 0.
    always_comb begin
        MemWrite = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        PCSrc    = 2'b00;
        pc_write = 1'b0;
        branch   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB  = 2'b01;
                IRWrite  = 1'b1;
                pc_write = 1'b1;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                IorD = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BEQEX: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b01;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            S_JEX: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // PC loads on unconditional writes or a taken branch.
    assign PCEn  = pc_write | (branch & Zero);
    assign State = state_q;

endmodule
